// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC read sequencer: the register address
// list walked by each scan and the sequencer state encoding.
package rtc_pkg;

   localparam logic [7:0] ADDR_SEG   = 8'h21;
   localparam logic [7:0] ADDR_MIN   = 8'h22;
   localparam logic [7:0] ADDR_HOUR  = 8'h23;
   localparam logic [7:0] ADDR_DAY   = 8'h24;
   localparam logic [7:0] ADDR_MONTH = 8'h25;
   localparam logic [7:0] ADDR_YEAR  = 8'h26;

   localparam int N_REGS = 6;

   // Element [i] is the register read at scan index i.
   localparam logic [5:0][7:0] ADDR_TABLE = {ADDR_YEAR, ADDR_MONTH, ADDR_DAY,
                                             ADDR_HOUR, ADDR_MIN, ADDR_SEG};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_NEXT   = 3'd3,
      ST_GAP    = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

   function automatic logic [7:0] addr_of(input logic [2:0] idx);
      return (idx < 3'd6) ? ADDR_TABLE[idx] : ADDR_SEG;
   endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Signal bundle between the read sequencer, the read-cycle engine and the
// time consumers; master is the sequencer side.
interface rtc_read_sequencer_if;
   import rtc_pkg::*;

   // Engine handshake: rd_start is a one-cycle request with addr_out held
   // until the engine answers with a one-cycle read_end carrying data_in.
   // Only one request is outstanding; read_end outside a wait is ignored.
   logic       scan_req;
   logic       read_end;
   logic [7:0] data_in;
   logic       rd_start;
   logic [7:0] addr_out;
   logic       busy;
   logic       scan_done;
   logic       timeout_err;
   logic [7:0] seg;
   logic [7:0] min;
   logic [7:0] hour;
   logic [7:0] day;
   logic [7:0] month;
   logic [7:0] year;
   state_t     dbg_state;

   modport master (
      input  scan_req, read_end, data_in,
      output rd_start, addr_out, busy, scan_done, timeout_err,
      output seg, min, hour, day, month, year, dbg_state
   );

   modport slave (
      output scan_req, read_end, data_in,
      input  rd_start, addr_out, busy, scan_done, timeout_err,
      input  seg, min, hour, day, month, year, dbg_state
   );

endinterface

// File: rtl/rtc_down_counter.sv
// Loadable down counter that stops at zero and flags it; serves as both the
// refresh timer and the per-read watchdog.
module rtc_down_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= RST_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Walks the six RTC time registers through the read-cycle engine and commits
// the captured bytes together once the whole scan has succeeded.
module rtc_read_sequencer
   import rtc_pkg::*;
#(
   parameter int REFRESH_CYCLES = 1000,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                  clk,
   input logic                  rst,
   rtc_read_sequencer_if.master bus
);

   localparam logic [15:0] REFRESH_RELOAD = 16'(REFRESH_CYCLES - 1);
   // Loaded with one less so the zero flag lands on the last cycle a reply is accepted.
   localparam logic [7:0]  WD_RELOAD      = 8'(TIMEOUT_CYCLES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_index;
   logic [7:0] r_shadow [N_REGS];
   logic [7:0] r_seg, r_min, r_hour, r_day, r_month, r_year;
   logic       r_timeout_err;

   logic       w_busy;
   logic       w_tick;
   logic       w_launch;
   logic       w_ref_zero;
   logic       w_wd_zero;
   logic       w_rd_start;
   logic       w_scan_done;

   assign w_busy   = (r_state != ST_IDLE);
   assign w_tick   = w_ref_zero & ~w_busy;
   assign w_launch = w_tick | bus.scan_req;

   // Held at reload while busy so the refresh period restarts on each return to idle.
   rtc_down_counter #(
      .WIDTH   (16),
      .RST_VAL (REFRESH_RELOAD)
   ) u_refresh (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_busy | w_ref_zero),
      .i_load_val (REFRESH_RELOAD),
      .i_dec      (1'b1),
      .o_zero     (w_ref_zero)
   );

   rtc_down_counter #(
      .WIDTH   (8),
      .RST_VAL (8'd0)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state == ST_ISSUE),
      .i_load_val (WD_RELOAD),
      .i_dec      (r_state == ST_WAIT),
      .o_zero     (w_wd_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_rd_start  = 1'b0;
      w_scan_done = 1'b0;
      case (r_state)
         ST_IDLE:   if (w_launch) w_next = ST_ISSUE;
         ST_ISSUE: begin
            w_rd_start = 1'b1;
            w_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.read_end)   w_next = ST_NEXT;
            else if (w_wd_zero) w_next = ST_IDLE;
         end
         ST_NEXT:   w_next = (r_index == 3'd5) ? ST_COMMIT : ST_GAP;
         ST_GAP:    w_next = ST_ISSUE;
         ST_COMMIT: begin
            w_scan_done = 1'b1;
            w_next      = ST_IDLE;
         end
         default:   w_next = ST_IDLE;
      endcase
      if ((r_state != ST_IDLE) && (r_index > 3'd5)) w_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_index       <= 3'd0;
         r_timeout_err <= 1'b0;
         r_seg         <= 8'h00;
         r_min         <= 8'h00;
         r_hour        <= 8'h00;
         r_day         <= 8'h00;
         r_month       <= 8'h00;
         r_year        <= 8'h00;
         for (int i = 0; i < N_REGS; i++) r_shadow[i] <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: if (w_launch) r_index <= 3'd0;
            ST_WAIT: begin
               if (bus.read_end) begin
                  if (r_index < 3'd6) r_shadow[r_index] <= bus.data_in;
               end else if (w_wd_zero) begin
                  r_timeout_err <= 1'b1;
                  for (int i = 0; i < N_REGS; i++) r_shadow[i] <= 8'h00;
               end
            end
            ST_NEXT: if (r_index != 3'd5) r_index <= r_index + 3'd1;
            ST_COMMIT: begin
               r_seg         <= r_shadow[0];
               r_min         <= r_shadow[1];
               r_hour        <= r_shadow[2];
               r_day         <= r_shadow[3];
               r_month       <= r_shadow[4];
               r_year        <= r_shadow[5];
               r_timeout_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_start    = w_rd_start;
   assign bus.addr_out    = addr_of(r_index);
   assign bus.busy        = w_busy;
   assign bus.scan_done   = w_scan_done;
   assign bus.timeout_err = r_timeout_err;
   assign bus.seg         = r_seg;
   assign bus.min         = r_min;
   assign bus.hour        = r_hour;
   assign bus.day         = r_day;
   assign bus.month       = r_month;
   assign bus.year        = r_year;
   assign bus.dbg_state   = r_state;

endmodule
